// File: rtl/dpi_pattern_gen.sv
// DPI/LTDC-style self-timed video source: panel timing plus four test patterns (RGB332).
// Optional macro PATGEN_BORDER_EN adds a 1-pixel white border around the active area.
module dpi_pattern_gen #(
  parameter int   H_ACTIVE  = 1024,
  parameter int   H_FP      = 24,
  parameter int   H_SYNC    = 136,
  parameter int   H_BP      = 160,
  parameter int   V_ACTIVE  = 768,
  parameter int   V_FP      = 3,
  parameter int   V_SYNC    = 6,
  parameter int   V_BP      = 29,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0
) (
  input  logic       pixelClock,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] patternSel,
  input  logic [7:0] solidColor,
  output logic [7:0] rgbOut,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic       frameStart
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BAR_W   = H_ACTIVE / 8;

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          frame_odd_q, frame_odd_d;
  logic [1:0]    pat_q, pat_d;
  logic          run_q, run_d;
  logic [7:0]    rgb_q, rgb_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d, fs_q, fs_d;

  logic [31:0]   h_ext_s, v_ext_s;
  logic [1:0]    pat_s;
  logic          active_s;
  logic [7:0]    pix_s;

  function automatic logic [7:0] bar_color(input logic [2:0] idx);
    logic [7:0] c;
    case (idx)
      3'd0:    c = 8'hFF;
      3'd1:    c = 8'h1F;
      3'd2:    c = 8'hF8;
      3'd3:    c = 8'h18;
      3'd4:    c = 8'hE7;
      3'd5:    c = 8'h07;
      3'd6:    c = 8'hE0;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // Pixel colour for the current counter position; a new selection applies from pixel (0,0).
  always_comb begin
    h_ext_s  = 32'(h_q);
    v_ext_s  = 32'(v_q);
    pat_s    = ((h_q == '0) && (v_q == '0)) ? patternSel : pat_q;
    active_s = (h_ext_s < H_ACTIVE) && (v_ext_s < V_ACTIVE);
    case (pat_s)
      2'd0:    pix_s = solidColor;
      2'd1:    pix_s = bar_color(3'(h_ext_s / BAR_W));
      // Square (0,0) of an even frame is white.
      2'd2:    pix_s = (h_ext_s[5] ^ v_ext_s[5] ^ frame_odd_q) ? 8'h00 : 8'hFF;
      default: pix_s = h_ext_s[7:0];
    endcase
`ifdef PATGEN_BORDER_EN
    if ((h_ext_s == 32'd0) || (h_ext_s == H_ACTIVE - 1) ||
        (v_ext_s == 32'd0) || (v_ext_s == V_ACTIVE - 1)) begin
      pix_s = 8'hFF;
    end else begin
      pix_s = pix_s;
    end
`endif
  end

  // Next-state: counters advance only once a cycle of enable has parked them at the origin.
  always_comb begin
    h_d         = h_q;
    v_d         = v_q;
    frame_odd_d = frame_odd_q;
    pat_d       = pat_q;
    run_d       = run_q;
    rgb_d       = 8'h00;
    de_d        = 1'b0;
    fs_d        = 1'b0;
    hsync_d     = ~HSYNC_POL;
    vsync_d     = ~VSYNC_POL;
    if (!enable) begin
      h_d   = '0;
      v_d   = '0;
      run_d = 1'b0;
    end else if (!run_q) begin
      h_d   = '0;
      v_d   = '0;
      run_d = 1'b1;
    end else begin
      pat_d   = pat_s;
      de_d    = active_s;
      fs_d    = (h_q == '0) && (v_q == '0);
      rgb_d   = active_s ? pix_s : 8'h00;
      hsync_d = ((h_ext_s >= H_ACTIVE + H_FP) && (h_ext_s < H_ACTIVE + H_FP + H_SYNC))
                ? HSYNC_POL : ~HSYNC_POL;
      vsync_d = ((v_ext_s >= V_ACTIVE + V_FP) && (v_ext_s < V_ACTIVE + V_FP + V_SYNC))
                ? VSYNC_POL : ~VSYNC_POL;
      if (h_ext_s == H_TOTAL - 1) begin
        h_d = '0;
        if (v_ext_s == V_TOTAL - 1) begin
          v_d         = '0;
          frame_odd_d = ~frame_odd_q;
        end else begin
          v_d = v_q + VW'(1);
        end
      end else begin
        h_d = h_q + HW'(1);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge pixelClock or posedge reset) begin
    if (reset) begin
      h_q         <= '0;
      v_q         <= '0;
      frame_odd_q <= 1'b0;
      pat_q       <= 2'd0;
      run_q       <= 1'b0;
      rgb_q       <= 8'h00;
      de_q        <= 1'b0;
      fs_q        <= 1'b0;
      hsync_q     <= ~HSYNC_POL;
      vsync_q     <= ~VSYNC_POL;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      frame_odd_q <= frame_odd_d;
      pat_q       <= pat_d;
      run_q       <= run_d;
      rgb_q       <= rgb_d;
      de_q        <= de_d;
      fs_q        <= fs_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
    end
  end

  assign rgbOut     = rgb_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign de         = de_q;
  assign frameStart = fs_q;

endmodule
